// File: rtl/gf8_pkg.sv
// rtl/gf8_pkg.sv - GF(2^8) constants, engine state type and xtime helper
package gf8_pkg;

  localparam int         GF_W        = 8;
  localparam logic [7:0] GF_POLY_AES = 8'h1B;
  localparam logic [7:0] GF_ONE      = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } pow_state_t;

  // Multiply by x, reducing by the implied x^8 term.
  function automatic logic [GF_W-1:0] gf8_xtime(input logic [GF_W-1:0] a,
                                                input logic [GF_W-1:0] poly);
    return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? poly : '0);
  endfunction

endpackage

// File: rtl/gf8_mul.sv
// rtl/gf8_mul.sv - combinational GF(2^8) multiplier, y = a*b mod {1,POLY}
module gf8_mul
  import gf8_pkg::*;
#(
  parameter logic [7:0] POLY = GF_POLY_AES
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  // Horner evaluation over b, MSB first, so each step is one xtime plus a conditional add.
  always_comb begin
    y = '0;
    for (int i = GF_W - 1; i >= 0; i--) begin
      y = gf8_xtime(y, POLY) ^ (b[i] ? a : 8'h00);
    end
  end

endmodule

// File: rtl/gf8_pow_seq.sv
// rtl/gf8_pow_seq.sv - square-and-multiply GF(2^8) exponentiation engine
// Optional inverse request input enabled by GF8_POW_INV_EN.
module gf8_pow_seq
  import gf8_pkg::*;
#(
  parameter logic [7:0] POLY  = GF_POLY_AES,
  parameter int         EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_base,
  input  logic [EXP_W-1:0] in_exp,
`ifdef GF8_POW_INV_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic             busy
);

  localparam int                IDX_W   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(EXP_W - 1);

  pow_state_t       state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       result_q, result_d;
  logic [7:0]       op_b;
  logic [7:0]       product;
  logic [EXP_W-1:0] exp_sel;

`ifdef GF8_POW_INV_EN
  if (EXP_W < 8) begin : g_exp_w_check
    $error("gf8_pow_seq: GF8_POW_INV_EN needs EXP_W >= 8");
  end
  assign exp_sel = in_inv ? EXP_W'(254) : in_exp;
`else
  assign exp_sel = in_exp;
`endif

  // Single shared multiplier: squaring in SQR, multiply by base in MUL.
  assign op_b = (state_q == MUL) ? base_q : acc_q;

  gf8_mul #(.POLY(POLY)) u_mul (
    .a (acc_q),
    .b (op_b),
    .y (product)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == SQR) || (state_q == MUL);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          base_d  = in_base;
          exp_d   = exp_sel;
          acc_d   = GF_ONE;
          idx_d   = IDX_TOP;
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = product;
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d  = DONE;
          result_d = product;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      MUL: begin
        acc_d = product;
        if (idx_q == '0) begin
          state_d  = DONE;
          result_d = product;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQR;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gf8_pow_seq.sv
// tb/tb_gf8_pow_seq.sv - directed self-checking bench for gf8_pow_seq
module tb_gf8_pow_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_base = 8'h00;
  logic [7:0] in_exp = 8'h00;
  logic       in_inv = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gf8_pow_seq #(.POLY(8'h1B), .EXP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_base    (in_base),
    .in_exp     (in_exp),
`ifdef GF8_POW_INV_EN
    .in_inv     (in_inv),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input string tag, input logic [7:0] b, input logic [7:0] e,
                           input logic inv);
    @(negedge clk);
    check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_base  = b;
    in_exp   = e;
    in_inv   = inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_base  = 8'hA5;
    in_exp   = ~e;
    in_inv   = ~inv;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
    end while (!out_valid && cnt < 40);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] b, input logic [7:0] e,
                     input logic inv, input logic [7:0] res, input int lat);
    int cnt;
    start_req(tag, b, e, inv);
    wait_done(cnt);
    check({tag, "_latency"}, 32'(cnt), 32'(lat));
    check({tag, "_result"}, 32'(out_result), 32'(res));
    release_result(tag);
  endtask

  initial begin
    int cnt;
    int seen;

    #1;
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(out_result), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("b02_e01", 8'h02, 8'h01, 1'b0, 8'h02, 9);
    run("b02_e08", 8'h02, 8'h08, 1'b0, 8'h1B, 9);
    run("b53_eFE", 8'h53, 8'hFE, 1'b0, 8'hCA, 15);
    run("b00_e00", 8'h00, 8'h00, 1'b0, 8'h01, 8);
    run("b00_e05", 8'h00, 8'h05, 1'b0, 8'h00, 10);
    run("bFF_e00", 8'hFF, 8'h00, 1'b0, 8'h01, 8);
    run("b01_eFF", 8'h01, 8'hFF, 1'b0, 8'h01, 16);
    run("b03_e03", 8'h03, 8'h03, 1'b0, 8'h0F, 10);
`ifdef GF8_POW_INV_EN
    run("inv_b53", 8'h53, 8'h05, 1'b1, 8'hCA, 15);
    run("inv_b00", 8'h00, 8'h05, 1'b1, 8'h00, 15);
`endif

    start_req("bp", 8'h02, 8'h08, 1'b0);
    wait_done(cnt);
    check("bp_latency", 32'(cnt), 32'd9);
    check("bp_result", 32'(out_result), 32'h1B);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_base  = 8'h77;
      in_exp   = 8'h01;
      @(posedge clk);
      #1;
      check("bp_hold_result", 32'(out_result), 32'h1B);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    start_req("rst", 8'h53, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    check("rst_no_result", 32'(seen), 32'd0);
    run("b03_e02", 8'h03, 8'h02, 1'b0, 8'h05, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
